// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg
// Shared types and constants for the data-RAM responder.
//   state_e          : handshake FSM states (IDLE, WAIT)
//   MAX_WAIT_CYCLES  : largest supported wait-state count (fits the 4-bit counter)
//   CNT_W            : wait counter width
//   idx_width()      : word-index width for a given memory depth
// -----------------------------------------------------------------------------
package dram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int MAX_WAIT_CYCLES = 15;
    localparam int CNT_W           = 4;

    // Number of address bits needed to select one word out of 'depth'.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_bw.sv
// -----------------------------------------------------------------------------
// sram_bw
// Single-port word memory with per-byte write enables and a registered read.
// Each byte lane is its own array so every lane maps onto a plain RAM
// primitive with a single write enable.
//   clk    : clock
//   en     : access enable (read or write)
//   we     : 1 = write, 0 = read
//   wstrb  : byte-lane write enables (only used when we = 1)
//   idx    : word index
//   wdata  : write data
//   rdata  : read data, updated only on a read access, held otherwise
// -----------------------------------------------------------------------------
module sram_bw
    import dram_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4096
) (
    input  logic                        clk,
    input  logic                        en,
    input  logic                        we,
    input  logic [XLEN/8-1:0]           wstrb,
    input  logic [idx_width(DEPTH)-1:0] idx,
    input  logic [XLEN-1:0]             wdata,
    output logic [XLEN-1:0]             rdata
);

    localparam int LANES = XLEN / 8;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd_q;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (wstrb[gi]) begin
                        lane_mem[idx] <= wdata[gi*8 +: 8];
                    end
                end else begin
                    lane_rd_q <= lane_mem[idx];
                end
            end
        end

        assign rdata[gi*8 +: 8] = lane_rd_q;
    end

endmodule

// File: rtl/dram_responder.sv
// -----------------------------------------------------------------------------
// dram_responder
// Target side of the core's data-RAM request interface. Accepts one request
// per cycle in which dram_req & dram_ready, with an optional number of wait
// states before dram_ready asserts for a held request.
//   clk         : clock
//   rst_b       : asynchronous active-low reset
//   dram_req    : request valid, held by the initiator until dram_ready
//   dram_write  : 1 = write, 0 = read
//   dram_wstrb  : byte-lane write enables
//   dram_addr   : byte address (bits [1:0] ignored)
//   dram_wdata  : lane-replicated write data
//   dram_ready  : request accepted this cycle (combinational)
//   dram_rdata  : read data, held until the next read accept
//   dram_rvalid : one-cycle pulse the cycle after a read accept
//   dram_err    : one-cycle pulse the cycle after an out-of-range accept
// -----------------------------------------------------------------------------
module dram_responder
    import dram_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              dram_req,
    input  logic              dram_write,
    input  logic [XLEN/8-1:0] dram_wstrb,
    input  logic [XLEN-1:0]   dram_addr,
    input  logic [XLEN-1:0]   dram_wdata,
    output logic              dram_ready,
    output logic [XLEN-1:0]   dram_rdata,
    output logic              dram_rvalid,
    output logic              dram_err
);

    localparam int IDX_W = idx_width(DEPTH);

    // Values above the counter range saturate rather than wrap.
    localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_EFF > 0) ? WAIT_EFF - 1 : 0);

    // One extra bit so DEPTH*4 never overflows the compare.
    localparam logic [XLEN:0] ADDR_LIMIT = (XLEN+1)'(longint'(DEPTH) * 4);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    // Forces dram_rdata to zero after reset or an out-of-range read; the RAM
    // output register itself has no reset.
    logic              zero_q, zero_d;

    logic              in_range;
    logic              accept;
    logic              ram_en;
    logic [XLEN-1:0]   ram_rdata;

    assign in_range = ({1'b0, dram_addr} < ADDR_LIMIT);

    always_comb begin
        dram_ready = 1'b0;
        if (rst_b) begin
            if (WAIT_EFF == 0) begin
                dram_ready = dram_req;
            end else begin
                dram_ready = (state_q == WAIT) && (cnt_q == CNT_LAST) && dram_req;
            end
        end
    end

    assign accept = dram_req & dram_ready;

    // Handshake FSM next state. With no wait states the FSM stays in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (WAIT_EFF != 0) begin
            case (state_q)
                IDLE: begin
                    if (dram_req) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
                WAIT: begin
                    // A dropped request is a flush: back to IDLE with no access.
                    if (!dram_req || accept) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rvalid_d = accept & ~dram_write;
        err_d    = accept & ~in_range;
        zero_d   = zero_q;
        if (accept && !dram_write) begin
            zero_d = ~in_range;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
        end
    end

    // Out-of-range accepts never touch the array.
    assign ram_en = accept & in_range;

    sram_bw #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (dram_write),
        .wstrb (dram_wstrb),
        .idx   (dram_addr[IDX_W+1:2]),
        .wdata (dram_wdata),
        .rdata (ram_rdata)
    );

    assign dram_rdata  = zero_q ? '0 : ram_rdata;
    assign dram_rvalid = rvalid_q;
    assign dram_err    = err_q;

endmodule

// File: tb/tb_dram_responder.sv
// -----------------------------------------------------------------------------
// tb_dram_responder
// Two responders side by side: index 0 with no wait states, index 1 with
// three. Both are driven from one step() task and compared every cycle
// against a reference model built from the handshake and memory rules.
// -----------------------------------------------------------------------------
module tb_dram_responder;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_b;

    logic        req_i   [2];
    logic        write_i [2];
    logic [3:0]  wstrb_i [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic        ready_o [2];
    logic        rvalid_o[2];
    logic        err_o   [2];
    logic [31:0] rdata_o [2];

    always #5 clk = ~clk;

    dram_responder #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_b(rst_b),
        .dram_req(req_i[0]), .dram_write(write_i[0]), .dram_wstrb(wstrb_i[0]),
        .dram_addr(addr_i[0]), .dram_wdata(wdata_i[0]),
        .dram_ready(ready_o[0]), .dram_rdata(rdata_o[0]),
        .dram_rvalid(rvalid_o[0]), .dram_err(err_o[0])
    );

    dram_responder #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_b(rst_b),
        .dram_req(req_i[1]), .dram_write(write_i[1]), .dram_wstrb(wstrb_i[1]),
        .dram_addr(addr_i[1]), .dram_wdata(wdata_i[1]),
        .dram_ready(ready_o[1]), .dram_rdata(rdata_o[1]),
        .dram_rvalid(rvalid_o[1]), .dram_err(err_o[1])
    );

    // Reference model state
    logic [31:0] mm    [2][DEPTH];
    bit          e_rv  [2];
    bit          e_err [2];
    logic [31:0] e_rd  [2];
    int          run   [2];   // consecutive request cycles not yet accepted
    bit          acc   [2];   // model accepted at the last edge
    bit          dut_rdy[2];  // DUT ready seen in the last step

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    // One clock: check DUT outputs against the model mid-cycle, then advance
    // the model at the rising edge using the (stable) inputs.
    task automatic step();
        bit er[2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            er[d]      = req_i[d] && (run[d] == wait_of(d));
            dut_rdy[d] = ready_o[d];
            check_eq($sformatf("d%0d_ready", d),  32'(ready_o[d]),  32'(er[d]));
            check_eq($sformatf("d%0d_rvalid", d), 32'(rvalid_o[d]), 32'(e_rv[d]));
            check_eq($sformatf("d%0d_err", d),    32'(err_o[d]),    32'(e_err[d]));
            check_eq($sformatf("d%0d_rdata", d),  rdata_o[d],       e_rd[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            acc[d]   = 1'b0;
            e_rv[d]  = 1'b0;
            e_err[d] = 1'b0;
            if (er[d]) begin
                acc[d] = 1'b1;
                run[d] = 0;
                if (in_range(addr_i[d])) begin
                    if (write_i[d]) begin
                        for (int l = 0; l < 4; l++) begin
                            if (wstrb_i[d][l]) mm[d][addr_i[d][13:2]][8*l +: 8] = wdata_i[d][8*l +: 8];
                        end
                    end else begin
                        e_rv[d] = 1'b1;
                        e_rd[d] = mm[d][addr_i[d][13:2]];
                    end
                end else begin
                    e_err[d] = 1'b1;
                    if (!write_i[d]) begin
                        e_rv[d] = 1'b1;
                        e_rd[d] = 32'h0;
                    end
                end
            end else if (req_i[d]) begin
                run[d]++;
            end else begin
                run[d] = 0;
            end
        end
        #1;
    endtask

    // Hold a request for up to max_cyc cycles or until accepted, then drop it.
    task automatic hold(input int d, input bit wr, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] w, input int max_cyc,
                        output int first_rdy, output int n_rdy);
        int cyc = 0;
        bit done = 1'b0;
        first_rdy = 0;
        n_rdy     = 0;
        req_i[d] = 1'b1; write_i[d] = wr; addr_i[d] = a; wstrb_i[d] = s; wdata_i[d] = w;
        while (!done && cyc < max_cyc) begin
            step();
            cyc++;
            if (dut_rdy[d]) begin
                n_rdy++;
                if (first_rdy == 0) first_rdy = cyc;
            end
            done = acc[d];
        end
        req_i[d] = 1'b0;
    endtask

    task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] w);
        int f, n;
        hold(d, wr, a, s, w, 20, f, n);
    endtask

    initial begin
        int f, n;
        for (int d = 0; d < 2; d++) begin
            req_i[d] = 1'b0; write_i[d] = 1'b0; wstrb_i[d] = 4'h0;
            addr_i[d] = 32'h0; wdata_i[d] = 32'h0;
            e_rv[d] = 1'b0; e_err[d] = 1'b0; e_rd[d] = 32'h0; run[d] = 0; acc[d] = 1'b0;
        end

        // Reset: ready must stay low even with a request present.
        rst_b    = 1'b0;
        req_i[0] = 1'b1;
        req_i[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_ready%0d", d),  32'(ready_o[d]),  32'h0);
            check_eq($sformatf("rst_rvalid%0d", d), 32'(rvalid_o[d]), 32'h0);
            check_eq($sformatf("rst_err%0d", d),    32'(err_o[d]),    32'h0);
            check_eq($sformatf("rst_rdata%0d", d),  rdata_o[d],       32'h0);
        end
        req_i[0] = 1'b0;
        req_i[1] = 1'b0;
        rst_b    = 1'b1;
        @(posedge clk);
        #1;

        // Fill a known window on both memories.
        for (int i = 0; i < 64; i++) begin
            txn(0, 1'b1, 32'(i * 4), 4'hF, $urandom());
            txn(1, 1'b1, 32'(i * 4), 4'hF, $urandom());
        end

        // No wait states: write then read back-to-back, data held afterwards.
        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h10, 4'h0, 32'h0);
        check_eq("rd_deadbeef", rdata_o[0], 32'hDEADBEEF);
        step();
        step();
        check_eq("rd_held", rdata_o[0], 32'hDEADBEEF);

        // Byte and half-word merges.
        txn(0, 1'b1, 32'h20, 4'hF, 32'h0);
        txn(0, 1'b1, 32'h21, 4'h2, 32'h55555555);
        txn(0, 1'b1, 32'h22, 4'hC, 32'hAAAAAAAA);
        txn(0, 1'b0, 32'h20, 4'h0, 32'h0);
        check_eq("byte_merge", rdata_o[0], 32'hAAAA5500);

        // Out of range and the top in-range word.
        txn(0, 1'b1, 32'h4000, 4'hF, 32'hFFFFFFFF);
        check_eq("oor_werr", 32'(err_o[0]), 32'h1);
        txn(0, 1'b0, 32'h0, 4'h0, 32'h0);
        txn(0, 1'b0, 32'h4000, 4'h0, 32'h0);
        check_eq("oor_rdata", rdata_o[0], 32'h0);
        check_eq("oor_rvalid", 32'(rvalid_o[0]), 32'h1);
        check_eq("oor_rerr", 32'(err_o[0]), 32'h1);
        txn(0, 1'b1, 32'h3FFC, 4'hF, 32'h0BADF00D);
        txn(0, 1'b0, 32'h3FFF, 4'h0, 32'h0);
        check_eq("top_word", rdata_o[0], 32'h0BADF00D);
        check_eq("top_noerr", 32'(err_o[0]), 32'h0);

        // Three wait states: held read is ready on its 4th cycle, once.
        txn(1, 1'b1, 32'h10, 4'hF, 32'hC0FFEE11);
        hold(1, 1'b0, 32'h10, 4'h0, 32'h0, 20, f, n);
        check_eq("w3_latency", 32'(f), 32'd4);
        check_eq("w3_one_accept", 32'(n), 32'd1);
        step();
        check_eq("w3_rdata", rdata_o[1], 32'hC0FFEE11);

        // Flush after two cycles, then a fresh request takes the full count.
        hold(1, 1'b0, 32'h20, 4'h0, 32'h0, 2, f, n);
        check_eq("flush_no_ready", 32'(n), 32'd0);
        step();
        hold(1, 1'b0, 32'h20, 4'h0, 32'h0, 20, f, n);
        check_eq("flush_relatency", 32'(f), 32'd4);

        // Randomized traffic, including flushes on the wait-state responder.
        for (int it = 0; it < 300; it++) begin
            int d = int'($urandom_range(0, 1));
            bit wr = 1'(($urandom() >> 3) & 1);
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom() | 32'h0000_4000;
            else a = 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
            hold(d, wr, a, 4'($urandom()), $urandom(), int'($urandom_range(1, 6)), f, n);
            repeat ($urandom_range(0, 2)) step();
        end

        // Async reset mid-WAIT while rdata holds a value.
        txn(0, 1'b1, 32'h30, 4'hF, 32'h12345678);
        txn(0, 1'b0, 32'h30, 4'h0, 32'h0);
        hold(1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 2, f, n);
        step();
        check_eq("pre_rst_rdata", rdata_o[0], 32'h12345678);
        req_i[1] = 1'b1;
        #2;
        rst_b = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("arst_rvalid%0d", d), 32'(rvalid_o[d]), 32'h0);
            check_eq($sformatf("arst_err%0d", d),    32'(err_o[d]),    32'h0);
            check_eq($sformatf("arst_rdata%0d", d),  rdata_o[d],       32'h0);
            check_eq($sformatf("arst_ready%0d", d),  32'(ready_o[d]),  32'h0);
            e_rv[d] = 1'b0; e_err[d] = 1'b0; e_rd[d] = 32'h0; run[d] = 0;
        end
        req_i[1] = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        txn(0, 1'b0, 32'h30, 4'h0, 32'h0);
        check_eq("post_rst_mem", rdata_o[0], 32'h12345678);
        txn(1, 1'b0, 32'h40, 4'h0, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
